// File: rtl/rob_queue_if.sv
// Bus between the reorder buffer and its neighbours: dispatch (alloc),
// functional-unit writeback, commit handshake and pipeline flush.
interface rob_queue_if #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32
);
  localparam int TAG_W = $clog2(DEPTH);

  logic             alloc;
  logic [WIDTH-1:0] alloc_data;
  logic [TAG_W-1:0] alloc_tag;
  logic             full;
  logic             empty;
  logic [TAG_W:0]   count;

  logic             wb_valid;
  logic [TAG_W-1:0] wb_tag;
  logic [WIDTH-1:0] wb_result;

  // Commit handshake: the head retires on a cycle where commit_valid and
  // commit_ready are both high at the clock edge; commit_valid never waits
  // on commit_ready, and ready while valid is low does nothing.
  logic             commit_valid;
  logic             commit_ready;
  logic [TAG_W-1:0] commit_tag;
  logic [WIDTH-1:0] commit_data;
  logic [WIDTH-1:0] commit_result;

  logic             flush;

  modport master (
    output alloc, alloc_data, wb_valid, wb_tag, wb_result, commit_ready, flush,
    input  alloc_tag, full, empty, count,
           commit_valid, commit_tag, commit_data, commit_result
  );

  modport slave (
    input  alloc, alloc_data, wb_valid, wb_tag, wb_result, commit_ready, flush,
    output alloc_tag, full, empty, count,
           commit_valid, commit_tag, commit_data, commit_result
  );
endinterface

// File: rtl/rob_queue.sv
// Reorder buffer: allocate at the tail in order, complete by tag in any
// order, retire from the head in program order.
module rob_queue #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32
) (
  input logic       clk,
  input logic       rst,
  rob_queue_if.slave bus
);
  localparam int TAG_W = $clog2(DEPTH);
  localparam logic [TAG_W:0] PTR_ONE = {{TAG_W{1'b0}}, 1'b1};

  // Pointers carry an extra wrap bit so full and empty stay distinguishable.
  logic [TAG_W:0]   head_ptr;
  logic [TAG_W:0]   tail_ptr;
  logic [TAG_W-1:0] head_idx;
  logic [TAG_W-1:0] tail_idx;
  logic [DEPTH-1:0] valid;
  logic [DEPTH-1:0] done;
  logic [WIDTH-1:0] data_mem   [DEPTH];
  logic [WIDTH-1:0] result_mem [DEPTH];

  logic full;
  logic empty;
  logic alloc_ok;
  logic wb_ok;
  logic commit_valid;
  logic fire;

  assign head_idx = head_ptr[TAG_W-1:0];
  assign tail_idx = tail_ptr[TAG_W-1:0];

  assign full  = (head_idx == tail_idx) && (head_ptr[TAG_W] != tail_ptr[TAG_W]);
  assign empty = (head_ptr == tail_ptr);

  assign alloc_ok     = bus.alloc & ~full;
  assign commit_valid = ~empty & valid[head_idx] & done[head_idx];
  assign fire         = commit_valid & bus.commit_ready;

  // The slot being allocated is never yet valid, but guard it explicitly so
  // a same-cycle writeback can never mark a fresh entry done.
  assign wb_ok = bus.wb_valid & valid[bus.wb_tag]
               & ~(alloc_ok && (bus.wb_tag == tail_idx));

  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      valid    <= '0;
      done     <= '0;
    end else begin
      if (alloc_ok) begin
        valid[tail_idx] <= 1'b1;
        done[tail_idx]  <= 1'b0;
        tail_ptr        <= tail_ptr + PTR_ONE;
      end
      if (wb_ok) begin
        done[bus.wb_tag] <= 1'b1;
      end
      // Retire last so a writeback to the firing head is dropped with it.
      if (fire) begin
        valid[head_idx] <= 1'b0;
        done[head_idx]  <= 1'b0;
        head_ptr        <= head_ptr + PTR_ONE;
      end
    end
  end

  // Payload storage needs no reset: valid/done gate every observable use.
  always_ff @(posedge clk) begin
    if (alloc_ok) begin
      data_mem[tail_idx] <= bus.alloc_data;
    end
    if (wb_ok) begin
      result_mem[bus.wb_tag] <= bus.wb_result;
    end
  end

  assign bus.alloc_tag     = tail_idx;
  assign bus.full          = full;
  assign bus.empty         = empty;
  assign bus.count         = tail_ptr - head_ptr;
  assign bus.commit_valid  = commit_valid;
  assign bus.commit_tag    = head_idx;
  assign bus.commit_data   = data_mem[head_idx];
  assign bus.commit_result = result_mem[head_idx];
endmodule

// File: tb/tb_rob_queue.sv
// Directed bench for rob_queue: reset, in-order commit, full drop, wrap,
// empty corner, flush and out-of-order completion.
module tb_rob_queue;
  localparam int DEPTH = 8;
  localparam int WIDTH = 32;
  localparam int TAG_W = 3;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  logic [WIDTH-1:0] exp_q[$];

  always #5 clk = ~clk;

  rob_queue_if #(.DEPTH(DEPTH), .WIDTH(WIDTH)) bus ();

  rob_queue #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // ---------------- driver tasks ----------------
  task automatic idle();
    bus.alloc        = 1'b0;
    bus.alloc_data   = '0;
    bus.wb_valid     = 1'b0;
    bus.wb_tag       = '0;
    bus.wb_result    = '0;
    bus.commit_ready = 1'b0;
    bus.flush        = 1'b0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    idle();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
  endtask

  task automatic drive_alloc(input logic [WIDTH-1:0] d);
    bus.alloc      = 1'b1;
    bus.alloc_data = d;
  endtask

  task automatic drive_wb(input logic [TAG_W-1:0] t, input logic [WIDTH-1:0] r);
    bus.wb_valid  = 1'b1;
    bus.wb_tag    = t;
    bus.wb_result = r;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    idle();
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %0b want 1", bus.empty); end
    checks++; if (bus.full !== 1'b0) begin errors++; $display("FAIL reset_full: got %0b want 0", bus.full); end
    checks++; if (bus.count !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", bus.count); end
    checks++; if (bus.commit_valid !== 1'b0) begin errors++; $display("FAIL reset_cv: got %0b want 0", bus.commit_valid); end
    checks++; if (bus.alloc_tag !== 3'd0) begin errors++; $display("FAIL reset_tag: got %0d want 0", bus.alloc_tag); end
  endtask

  task automatic test_in_order_commit();
    logic [WIDTH-1:0] d [3];
    d[0] = 32'h111; d[1] = 32'h222; d[2] = 32'h333;
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      checks++; if (bus.alloc_tag !== 3'(i)) begin errors++; $display("FAIL basic_alloc_tag: got %0d want %0d", bus.alloc_tag, i); end
      drive_alloc(d[i]);
      cyc();
    end
    idle();
    checks++; if (bus.count !== 4'd3) begin errors++; $display("FAIL basic_count: got %0d want 3", bus.count); end
    checks++; if (bus.commit_valid !== 1'b0) begin errors++; $display("FAIL basic_cv_pending: got %0b want 0", bus.commit_valid); end
    drive_wb(3'd1, 32'hA1);
    cyc();
    idle();
    checks++; if (bus.commit_valid !== 1'b0) begin errors++; $display("FAIL basic_cv_tag1_only: got %0b want 0", bus.commit_valid); end
    drive_wb(3'd0, 32'hA0);
    cyc();
    idle();
    checks++; if (bus.commit_valid !== 1'b1) begin errors++; $display("FAIL basic_cv_head_done: got %0b want 1", bus.commit_valid); end
    checks++; if (bus.commit_tag !== 3'd0) begin errors++; $display("FAIL basic_tag0: got %0d want 0", bus.commit_tag); end
    checks++; if (bus.commit_result !== 32'hA0) begin errors++; $display("FAIL basic_res0: got %0h want a0", bus.commit_result); end
    checks++; if (bus.commit_data !== 32'h111) begin errors++; $display("FAIL basic_data0: got %0h want 111", bus.commit_data); end
    bus.commit_ready = 1'b1;
    cyc();
    checks++; if (bus.commit_tag !== 3'd1 || bus.commit_valid !== 1'b1) begin errors++; $display("FAIL basic_tag1: got tag %0d cv %0b want 1/1", bus.commit_tag, bus.commit_valid); end
    checks++; if (bus.commit_result !== 32'hA1 || bus.commit_data !== 32'h222) begin errors++; $display("FAIL basic_res1: got %0h/%0h want a1/222", bus.commit_result, bus.commit_data); end
    cyc();
    checks++; if (bus.commit_valid !== 1'b0 || bus.commit_tag !== 3'd2) begin errors++; $display("FAIL basic_tag2_hold: got cv %0b tag %0d want 0/2", bus.commit_valid, bus.commit_tag); end
    cyc();
    checks++; if (bus.count !== 4'd1) begin errors++; $display("FAIL basic_ready_no_effect: got count %0d want 1", bus.count); end
    drive_wb(3'd2, 32'hA2);
    cyc();
    bus.wb_valid = 1'b0;
    checks++; if (bus.commit_valid !== 1'b1 || bus.count !== 4'd1) begin errors++; $display("FAIL basic_wb_latency: got cv %0b count %0d want 1/1", bus.commit_valid, bus.count); end
    cyc();
    idle();
    checks++; if (bus.empty !== 1'b1 || bus.count !== 4'd0) begin errors++; $display("FAIL basic_drain: got empty %0b count %0d want 1/0", bus.empty, bus.count); end
  endtask

  task automatic test_full_drop();
    logic [WIDTH-1:0] want;
    apply_reset();
    for (int i = 0; i < 8; i++) begin
      drive_alloc(32'h100 + 32'(i));
      cyc();
    end
    idle();
    checks++; if (bus.full !== 1'b1 || bus.count !== 4'd8) begin errors++; $display("FAIL full_set: got full %0b count %0d want 1/8", bus.full, bus.count); end
    checks++; if (bus.alloc_tag !== 3'd0) begin errors++; $display("FAIL full_tail_wrap: got %0d want 0", bus.alloc_tag); end
    drive_wb(3'd0, 32'h50);
    cyc();
    idle();
    checks++; if (bus.commit_valid !== 1'b1) begin errors++; $display("FAIL full_head_done: got %0b want 1", bus.commit_valid); end
    drive_alloc(32'hBEEF);
    bus.commit_ready = 1'b1;
    cyc();
    idle();
    checks++; if (bus.count !== 4'd7 || bus.full !== 1'b0) begin errors++; $display("FAIL full_drop_count: got count %0d full %0b want 7/0", bus.count, bus.full); end
    checks++; if (bus.alloc_tag !== 3'd0 || bus.commit_tag !== 3'd1) begin errors++; $display("FAIL full_drop_ptrs: got tail %0d head %0d want 0/1", bus.alloc_tag, bus.commit_tag); end
    drive_alloc(32'hCAFE);
    cyc();
    idle();
    for (int t = 1; t < 8; t++) begin
      drive_wb(3'(t), 32'h60 + 32'(t));
      cyc();
    end
    drive_wb(3'd0, 32'h60);
    cyc();
    idle();
    bus.commit_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      want = (k < 7) ? 32'h101 + 32'(k) : 32'hCAFE;
      checks++; if (bus.commit_valid !== 1'b1 || bus.commit_data !== want) begin errors++; $display("FAIL full_drain_%0d: got cv %0b data %0h want 1/%0h", k, bus.commit_valid, bus.commit_data, want); end
      cyc();
    end
    idle();
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL full_drained_empty: got %0b want 1", bus.empty); end
  endtask

  task automatic test_wrap();
    int n_alloc = 0;
    int n_commit = 0;
    int cycles = 0;
    logic pend = 1'b0;
    logic [TAG_W-1:0] pend_tag = '0;
    logic [WIDTH-1:0] pend_data = '0;
    logic [WIDTH-1:0] d;
    apply_reset();
    exp_q.delete();
    while (n_commit < 12 && cycles < 60) begin
      idle();
      bus.commit_ready = 1'b1;
      if (pend) drive_wb(pend_tag, pend_data ^ 32'hFFFF_0000);
      if (bus.commit_valid === 1'b1) begin
        checks++; if (exp_q.size() == 0) begin errors++; $display("FAIL wrap_unexpected_commit: got tag %0d want none", bus.commit_tag); end
        else begin
          checks++; if (bus.commit_tag !== 3'(n_commit % 8)) begin errors++; $display("FAIL wrap_commit_tag: got %0d want %0d", bus.commit_tag, n_commit % 8); end
          checks++; if (bus.commit_data !== exp_q[0] || bus.commit_result !== (exp_q[0] ^ 32'hFFFF_0000)) begin errors++; $display("FAIL wrap_commit_order: got %0h/%0h want %0h", bus.commit_data, bus.commit_result, exp_q[0]); end
          void'(exp_q.pop_front());
        end
        n_commit++;
      end
      pend = 1'b0;
      if (n_alloc < 12) begin
        d = 32'h200 + 32'(n_alloc);
        checks++; if (bus.alloc_tag !== 3'(n_alloc % 8)) begin errors++; $display("FAIL wrap_alloc_tag: got %0d want %0d", bus.alloc_tag, n_alloc % 8); end
        drive_alloc(d);
        exp_q.push_back(d);
        pend = 1'b1;
        pend_tag = 3'(n_alloc % 8);
        pend_data = d;
        n_alloc++;
      end
      cyc();
      cycles++;
      checks++; if (bus.count > 4'd8) begin errors++; $display("FAIL wrap_count_bound: got %0d want <=8", bus.count); end
    end
    idle();
    checks++; if (n_commit != 12) begin errors++; $display("FAIL wrap_timeout: got %0d commits want 12", n_commit); end
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL wrap_final_empty: got %0b want 1", bus.empty); end
  endtask

  task automatic test_empty_corner();
    apply_reset();
    drive_alloc(32'h333);
    bus.commit_ready = 1'b1;
    checks++; if (bus.commit_valid !== 1'b0) begin errors++; $display("FAIL empty_cv_same_cycle: got %0b want 0", bus.commit_valid); end
    cyc();
    idle();
    checks++; if (bus.count !== 4'd1 || bus.commit_valid !== 1'b0) begin errors++; $display("FAIL empty_alloc_only: got count %0d cv %0b want 1/0", bus.count, bus.commit_valid); end
    drive_wb(3'd5, 32'h55);
    cyc();
    idle();
    checks++; if (bus.count !== 4'd1 || bus.commit_valid !== 1'b0 || bus.alloc_tag !== 3'd1) begin errors++; $display("FAIL empty_wb_invalid: got count %0d cv %0b tail %0d want 1/0/1", bus.count, bus.commit_valid, bus.alloc_tag); end
    drive_wb(3'd0, 32'h66);
    cyc();
    idle();
    checks++; if (bus.commit_valid !== 1'b1 || bus.commit_data !== 32'h333 || bus.commit_result !== 32'h66) begin errors++; $display("FAIL empty_head_ok: got cv %0b %0h/%0h want 1/333/66", bus.commit_valid, bus.commit_data, bus.commit_result); end
  endtask

  task automatic test_flush();
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      drive_alloc(32'h500 + 32'(i));
      cyc();
    end
    idle();
    for (int t = 0; t < 3; t++) begin
      drive_wb(3'(t), 32'h70 + 32'(t));
      cyc();
    end
    idle();
    checks++; if (bus.commit_valid !== 1'b1 || bus.count !== 4'd5) begin errors++; $display("FAIL flush_pre: got cv %0b count %0d want 1/5", bus.commit_valid, bus.count); end
    bus.flush = 1'b1;
    drive_alloc(32'hDEAD);
    drive_wb(3'd3, 32'h73);
    bus.commit_ready = 1'b1;
    cyc();
    idle();
    checks++; if (bus.empty !== 1'b1 || bus.count !== 4'd0) begin errors++; $display("FAIL flush_empty: got empty %0b count %0d want 1/0", bus.empty, bus.count); end
    checks++; if (bus.alloc_tag !== 3'd0 || bus.commit_valid !== 1'b0) begin errors++; $display("FAIL flush_state: got tail %0d cv %0b want 0/0", bus.alloc_tag, bus.commit_valid); end
    drive_wb(3'd0, 32'h80);
    cyc();
    idle();
    checks++; if (bus.commit_valid !== 1'b0 || bus.count !== 4'd0) begin errors++; $display("FAIL flush_stale_wb: got cv %0b count %0d want 0/0", bus.commit_valid, bus.count); end
    drive_alloc(32'h777);
    cyc();
    idle();
    drive_wb(3'd0, 32'h81);
    cyc();
    idle();
    checks++; if (bus.commit_valid !== 1'b1 || bus.commit_data !== 32'h777 || bus.count !== 4'd1) begin errors++; $display("FAIL flush_reuse: got cv %0b data %0h count %0d want 1/777/1", bus.commit_valid, bus.commit_data, bus.count); end
  endtask

  task automatic test_out_of_order();
    logic [TAG_W-1:0] order [4];
    order[0] = 3'd3; order[1] = 3'd1; order[2] = 3'd2; order[3] = 3'd0;
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      drive_alloc(32'h400 + 32'(i));
      cyc();
    end
    idle();
    for (int k = 0; k < 4; k++) begin
      drive_wb(order[k], 32'hC0 + 32'(order[k]));
      if (k == 3) bus.commit_ready = 1'b1;
      checks++; if (bus.commit_valid !== 1'b0) begin errors++; $display("FAIL ooo_cv_early_%0d: got %0b want 0", k, bus.commit_valid); end
      cyc();
    end
    bus.wb_valid = 1'b0;
    for (int t = 0; t < 4; t++) begin
      checks++; if (bus.commit_valid !== 1'b1 || bus.commit_tag !== 3'(t)) begin errors++; $display("FAIL ooo_commit_%0d: got cv %0b tag %0d want 1/%0d", t, bus.commit_valid, bus.commit_tag, t); end
      checks++; if (bus.commit_result !== 32'hC0 + 32'(t) || bus.commit_data !== 32'h400 + 32'(t)) begin errors++; $display("FAIL ooo_payload_%0d: got %0h/%0h", t, bus.commit_data, bus.commit_result); end
      cyc();
    end
    idle();
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL ooo_empty: got %0b want 1", bus.empty); end
  endtask

  initial begin
    rst = 1'b1;
    idle();
    test_reset();
    test_in_order_commit();
    test_full_drop();
    test_wrap();
    test_empty_corner();
    test_flush();
    test_out_of_order();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
